// File: rtl/cache_tg_pkg.sv
// Shared types and constants for the cache traffic generator.
// Holds the run modes, sequencer states and the fixed access size.
package cache_tg_pkg;

    typedef enum logic [1:0] {
        MODE_WR         = 2'd0,
        MODE_RD         = 2'd1,
        MODE_WR_THEN_RD = 2'd2,
        MODE_ALT        = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [2:0] REQ_SIZE_8B = 3'd3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_traffic_gen_if.sv
// CPU-side request/response port of the L1 data cache.
// The generator is the master; the cache (or a model of it) is the slave.
interface cache_traffic_gen_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned RDATA_W = 128
);
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic [2:0]         req_size;
    logic               rsp_valid;
    logic [RDATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cache_tg_pattern.sv
// Strided address and data pattern generator, purely combinational.
// The issue path and the read-check path use the same pattern function.
module cache_tg_pattern #(
    parameter int unsigned        ADDR_W    = 64,
    parameter int unsigned        DATA_W    = 64,
    parameter int unsigned        IDX_W     = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(4096),
    parameter logic [ADDR_W-1:0]  STRIDE    = ADDR_W'(4096),
    parameter logic [DATA_W-1:0]  SEED      = DATA_W'(64'hA5A5_0000_0000_0000)
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] idx_addr,
    output logic [DATA_W-1:0] idx_data,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic [DATA_W-1:0] chk_data
);
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return SEED ^ DATA_W'(a[31:0]);
    endfunction

    // Address arithmetic is ADDR_W wide so it wraps silently.
    assign idx_addr = BASE_ADDR + ADDR_W'(idx) * STRIDE;
    assign idx_data = pattern(idx_addr);
    assign chk_data = pattern(chk_addr);
endmodule

// File: rtl/cache_traffic_gen.sv
// Strided request sequencer for the L1 data cache CPU port.
// state    | meaning
// IDLE     | waiting for start
// ISSUE    | req_valid high, holding request until req_ready
// WAIT_RSP | one request outstanding, timeout running
// DONE     | one-cycle done pulse, then back to IDLE
module cache_traffic_gen
    import cache_tg_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 64,
    parameter int unsigned        DATA_W    = 64,
    parameter int unsigned        RDATA_W   = 128,
    parameter int unsigned        NUM_OPS   = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(4096),
    parameter logic [ADDR_W-1:0]  STRIDE    = ADDR_W'(4096),
    parameter logic [DATA_W-1:0]  SEED      = DATA_W'(64'hA5A5_0000_0000_0000),
    parameter int unsigned        TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    cache_traffic_gen_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          err_count,
    output logic [15:0]          op_count
);
    localparam int unsigned IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_sel;
    logic [IDX_W-1:0]   idx_q, nxt_idx, pat_idx;
    logic               pass_q, nxt_pass, nxt_we;
    logic [TMR_W-1:0]   tmr_q;
    logic               req_we_q;
    logic [ADDR_W-1:0]  req_addr_q, pat_addr;
    logic [DATA_W-1:0]  req_wdata_q, pat_data, chk_data;
    logic [15:0]        err_q, ops_q;
    logic               load_req, accept, rsp_hit, timed_out, op_end;
    logic               last_idx, last_op, rd_bad;
    logic               unused_rsp;

    cache_tg_pattern #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .BASE_ADDR (BASE_ADDR),
        .STRIDE    (STRIDE),
        .SEED      (SEED)
    ) u_pattern (
        .idx      (pat_idx),
        .idx_addr (pat_addr),
        .idx_data (pat_data),
        .chk_addr (req_addr_q),
        .chk_data (chk_data)
    );

    assign mode_sel  = (state_q == IDLE) ? mode_e'(mode) : mode_q;
    assign accept    = (state_q == ISSUE) && bus.req_ready;
    assign rsp_hit   = (state_q == WAIT_RSP) && bus.rsp_valid;
    assign timed_out = (state_q == WAIT_RSP) && !bus.rsp_valid && (tmr_q == '0);
    assign op_end    = rsp_hit || timed_out;
    assign last_idx  = (idx_q == IDX_W'(NUM_OPS - 1));
    assign last_op   = last_idx && ((mode_q != MODE_WR_THEN_RD) || pass_q);
    assign rd_bad    = rsp_hit && !req_we_q && (bus.rsp_data[DATA_W-1:0] != chk_data);
    assign unused_rsp = ^bus.rsp_data;

    // Index/pass of the request about to be loaded; ALT reads revisit idx-1.
    always_comb begin
        nxt_idx  = '0;
        nxt_pass = 1'b0;
        nxt_we   = 1'b1;
        if (state_q != IDLE) begin
            if (last_idx) begin
                nxt_idx  = '0;
                nxt_pass = 1'b1;
            end else begin
                nxt_idx  = idx_q + IDX_W'(1);
                nxt_pass = pass_q;
            end
        end
        case (mode_sel)
            MODE_WR:         nxt_we = 1'b1;
            MODE_RD:         nxt_we = 1'b0;
            MODE_WR_THEN_RD: nxt_we = !nxt_pass;
            MODE_ALT:        nxt_we = !nxt_idx[0];
            default:         nxt_we = 1'b1;
        endcase
        pat_idx = (mode_sel == MODE_ALT && nxt_idx[0]) ? nxt_idx - IDX_W'(1) : nxt_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ISSUE;
                    load_req = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.req_ready) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (op_end) begin
                    if (last_op) begin
                        state_d = DONE;
                    end else begin
                        state_d  = ISSUE;
                        load_req = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_WR;
            idx_q       <= '0;
            pass_q      <= 1'b0;
            tmr_q       <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            err_q       <= '0;
            ops_q       <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                mode_q <= mode_e'(mode);
                err_q  <= '0;
                ops_q  <= '0;
            end
            if (load_req) begin
                idx_q       <= nxt_idx;
                pass_q      <= nxt_pass;
                req_we_q    <= nxt_we;
                req_addr_q  <= pat_addr;
                req_wdata_q <= pat_data;
            end
            // Down-counter: terminal count 0 marks TIMEOUT cycles since acceptance.
            if (accept)
                tmr_q <= TMR_W'(TIMEOUT);
            else if (state_q == WAIT_RSP && tmr_q != '0)
                tmr_q <= tmr_q - TMR_W'(1);
            if (op_end) begin
                ops_q <= sat_inc(ops_q);
                if (rd_bad || timed_out) err_q <= sat_inc(err_q);
            end
        end
    end

    assign bus.req_valid = (state_q == ISSUE);
    assign bus.req_we    = req_we_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_wdata = req_wdata_q;
    assign bus.req_size  = REQ_SIZE_8B;
    assign busy          = (state_q == ISSUE) || (state_q == WAIT_RSP);
    assign done          = (state_q == DONE);
    assign err_count     = err_q;
    assign op_count      = ops_q;
endmodule

// File: tb/tb_cache_traffic_gen.sv
// Bench for cache_traffic_gen: a memory-backed cache model answers requests,
// and a run-level reference derives the expected request stream and error count.
module tb_cache_traffic_gen;
    import cache_tg_pkg::*;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned RDATA_W = 128;
    localparam int unsigned NUM_OPS = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [63:0] BASE    = 64'd4096;
    localparam logic [63:0] STR     = 64'd4096;
    localparam logic [63:0] SEED    = 64'hA5A5_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  mode;
    logic        busy, done;
    logic [15:0] err_count, op_count;

    cache_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RDATA_W(RDATA_W)) bus ();

    cache_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RDATA_W(RDATA_W), .NUM_OPS(NUM_OPS),
        .BASE_ADDR(BASE), .STRIDE(STR), .SEED(SEED), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bus(bus),
        .busy(busy), .done(done), .err_count(err_count), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
    } req_t;

    int n_chk = 0, n_pass = 0;
    req_t exp_q[$];
    logic [63:0] mem [logic [63:0]];

    int stall_op = -1, stall_left = 0, drop_op = -1, fixed_lat = 2;
    bit rnd = 1'b0, spur = 1'b0;
    logic [63:0] corrupt_addr = 64'h0;

    int acc_idx = 0, exp_err = 0, done_cnt = 0, rsp_cnt = 0, cyc = 0, drop_t = -1;
    bit acc_flag = 1'b0, pend = 1'b0;
    logic        cap_we;
    logic [63:0] cap_addr, cap_wdata;
    logic [2:0]  cap_size;
    logic [127:0] rsp_hold;

    function automatic logic [63:0] pat(input logic [63:0] a);
        return SEED ^ {32'h0, a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic got_req();
        req_t e;
        logic [63:0] d;
        chk("valid_drop_after_accept", bus.req_valid, 1'b0);
        if (exp_q.size() == 0) begin
            chk("extra_req", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk("req_we", cap_we, e.we);
            chk("req_addr", cap_addr, e.addr);
            if (e.we) chk("req_wdata", cap_wdata, e.data);
            chk("req_size", cap_size, 3'd3);
        end
        if (cap_we) mem[cap_addr] = cap_wdata;
        if (acc_idx == drop_op) begin
            drop_t = cyc;
            exp_err++;
        end else begin
            if (cap_we) begin
                rsp_hold = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                d = mem.exists(cap_addr) ? mem[cap_addr] : 64'h0;
                if (cap_addr == corrupt_addr) d[0] = ~d[0];
                if (d != pat(cap_addr)) exp_err++;
                rsp_hold = {$urandom, $urandom, d};
            end
            rsp_cnt = rnd ? int'($urandom_range(1, 5)) : fixed_lat;
        end
        acc_idx++;
    endtask

    task automatic slave();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.rsp_valid = 1'b0;
            if (done) done_cnt++;
            if (rst) begin
                acc_flag = 1'b0;
                pend = 1'b0;
                rsp_cnt = 0;
                drop_t = -1;
                bus.req_ready = 1'b0;
                continue;
            end
            if (acc_flag) begin
                acc_flag = 1'b0;
                got_req();
            end
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = rsp_hold;
                end
            end else if (spur && $urandom_range(0, 7) == 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (pend) begin
                chk("hold_valid", bus.req_valid, 1'b1);
                chk("hold_we", bus.req_we, cap_we);
                chk("hold_addr", bus.req_addr, cap_addr);
                chk("hold_wdata", bus.req_wdata, cap_wdata);
            end
            if (drop_t >= 0 && bus.req_valid) begin
                chk("timeout_len", cyc - drop_t, TIMEOUT + 1);
                drop_t = -1;
            end
            if (bus.req_valid) begin
                cap_we    = bus.req_we;
                cap_addr  = bus.req_addr;
                cap_wdata = bus.req_wdata;
                cap_size  = bus.req_size;
                if (acc_idx == stall_op && stall_left > 0) begin
                    bus.req_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.req_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                acc_flag = bus.req_ready;
                pend     = !bus.req_ready;
            end else begin
                bus.req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                pend = 1'b0;
            end
        end
    endtask

    task automatic build_exp(input logic [1:0] m, output int n);
        req_t e;
        int idx, pss, ai;
        n = (m == 2'd2) ? 2 * NUM_OPS : NUM_OPS;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            idx = k % NUM_OPS;
            pss = k / NUM_OPS;
            case (m)
                2'd0:    e.we = 1'b1;
                2'd1:    e.we = 1'b0;
                2'd2:    e.we = (pss == 0);
                default: e.we = (idx % 2 == 0);
            endcase
            ai = (m == 2'd3 && idx % 2 == 1) ? idx - 1 : idx;
            e.addr = BASE + 64'(ai) * STR;
            e.data = pat(e.addr);
            exp_q.push_back(e);
        end
        acc_idx = 0;
        exp_err = 0;
        drop_t  = -1;
    endtask

    task automatic run(input logic [1:0] m, input string name);
        int n, c, base_done;
        build_exp(m, n);
        base_done = done_cnt;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy"}, busy, 1'b1);
        c = 0;
        while (!done && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_finished"}, done, 1'b1);
        chk({name, "_op_count"}, op_count, 16'(n));
        chk({name, "_err_count"}, err_count, 16'(exp_err));
        chk({name, "_missing_reqs"}, exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        chk({name, "_done_pulses"}, done_cnt - base_done, 1);
        chk({name, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int n, c, base_done;
        rst = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        fork
            slave();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_valid", bus.req_valid, 1'b0);
        chk("rst_we", bus.req_we, 1'b0);
        chk("rst_addr", bus.req_addr, 64'h0);
        chk("rst_wdata", bus.req_wdata, 64'h0);
        chk("rst_size", bus.req_size, 3'd3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err_count, 16'h0);
        chk("rst_ops", op_count, 16'h0);
        rst = 1'b0;
        @(negedge clk);

        run(2'd0, "wr");
        run(2'd2, "wr_then_rd");

        corrupt_addr = 64'd8192;
        run(2'd1, "rd_corrupt");
        chk("rd_corrupt_err_is_one", err_count, 16'd1);
        corrupt_addr = 64'h0;

        stall_op = 1;
        stall_left = 5;
        run(2'd0, "wr_stall");
        stall_op = -1;

        drop_op = 1;
        run(2'd0, "wr_timeout");
        chk("timeout_err_is_one", err_count, 16'd1);
        drop_op = -1;

        fixed_lat = TIMEOUT + 1;
        run(2'd1, "rd_late_rsp");
        fixed_lat = 2;

        run(2'd3, "alt");

        // Reset while a request is outstanding.
        fixed_lat = 20;
        build_exp(2'd0, n);
        base_done = done_cnt;
        @(negedge clk);
        mode = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (acc_idx < 1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("midrun_accepted", acc_idx, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_valid", bus.req_valid, 1'b0);
        chk("midrun_rst_busy", busy, 1'b0);
        chk("midrun_rst_done", done, 1'b0);
        chk("midrun_rst_addr", bus.req_addr, 64'h0);
        chk("midrun_rst_wdata", bus.req_wdata, 64'h0);
        chk("midrun_rst_ops", op_count, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("midrun_no_done", done_cnt - base_done, 0);
        chk("midrun_stays_idle", busy, 1'b0);
        fixed_lat = 2;
        run(2'd0, "post_rst");

        rnd = 1'b1;
        spur = 1'b1;
        for (int r = 0; r < 8; r++) begin
            corrupt_addr = ($urandom_range(0, 1) == 0) ? 64'h0 : BASE + 64'($urandom_range(0, NUM_OPS - 1)) * STR;
            run(2'($urandom_range(0, 3)), $sformatf("rand%0d", r));
        end
        rnd = 1'b0;
        spur = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
